// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared capture FSM encoding and default widths
// for adc_capture_ctrl and its AXI-Stream bundle.
package adc_capture_pkg;

   localparam int DATA_W_DEF = 12;
   localparam int LEN_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      FLUSH   = 2'd3
   } state_t;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// adc_capture_ctrl_if: AXI-Stream master bundle of adc_capture_ctrl.
// tuser exists only when ADC_CAPTURE_CTRL_TUSER_EN is defined.
interface adc_capture_ctrl_if
   import adc_capture_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);

   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;
`ifdef ADC_CAPTURE_CTRL_TUSER_EN
   logic              tuser;

   modport master (output tdata, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tvalid, tlast, tuser, output tready);
`else
   modport master (output tdata, tvalid, tlast, input tready);
   modport slave  (input tdata, tvalid, tlast, output tready);
`endif

endinterface

// File: rtl/adc_capture_ctrl_skid2.sv
// axis_skid2: 2-entry output buffer feeding the stream port.
// The head entry only changes on a pop or when empty, so tdata holds under stall.
module axis_skid2 #(
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              tready,
   output logic [DATA_W-1:0] tdata,
   output logic              tvalid,
   output logic [1:0]        occ
);

   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] tail;
   logic [1:0]        count;
   logic              pop;

   assign pop    = tvalid & tready;
   assign tvalid = (count != 2'd0);
   assign tdata  = head;
   assign occ    = count;

   // push/pop the two entries; head always holds the oldest beat
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else begin
         count <= count + {1'b0, load} - {1'b0, pop};
         case ({load, pop})
            2'b10: begin
               if (count == 2'd0) head <= load_data;
               else               tail <= load_data;
            end
            2'b01: head <= tail;
            2'b11: begin
               if (count == 2'd1) begin
                  head <= load_data;
               end else begin
                  head <= tail;
                  tail <= load_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: trigger-armed ADC capture into a FIFO, drained to AXI-Stream.
// Optional macro ADC_CAPTURE_CTRL_TUSER_EN adds m_axis.tuser (first beat / overflow flag).
module adc_capture_ctrl
   import adc_capture_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_start,
   input  logic               cfg_abort,
   input  logic [LEN_W-1:0]   cfg_pkt_len,
   input  logic               trig,
   input  logic [DATA_W-1:0]  adc_data,
   input  logic               adc_valid,
   output logic [DATA_W-1:0]  fifo_wr_data,
   output logic               fifo_write,
   output logic               fifo_read,
   input  logic [DATA_W-1:0]  fifo_rd_data,
   input  logic               fifo_full,
   input  logic               fifo_empty,
   adc_capture_ctrl_if.master m_axis,
   output logic               busy,
   output logic               done,
   output logic               overflow
);

   state_t           state;
   state_t           state_nxt;
   logic [LEN_W-1:0] last_idx;
   logic [LEN_W-1:0] wr_cnt;
   logic [LEN_W-1:0] out_cnt;
   logic             inflight;
   logic             wr_ok;
   logic             fire;
   logic             is_last;
   logic             active;
   logic             room;
   logic             start_ok;
   logic [1:0]       occ;
   logic [2:0]       held;
   logic [LEN_W:0]   issued;

   assign fire     = m_axis.tvalid & m_axis.tready;
   assign is_last  = (out_cnt == last_idx);
   assign active   = (state == CAPTURE) || (state == FLUSH);
   assign start_ok = (state == IDLE) & cfg_start & ~cfg_abort;

   // a beat leaving this cycle frees its slot, which keeps 1 beat/cycle
   assign held   = {1'b0, occ} + {2'b00, inflight};
   assign room   = held < (3'd2 + {2'b00, fire});
   assign issued = {1'b0, out_cnt} + (LEN_W+1)'(occ) + (LEN_W+1)'(inflight);

   assign fifo_wr_data = adc_data;
   assign fifo_write   = wr_ok & ~cfg_abort & ~rst;
   assign fifo_read    = active & ~fifo_empty & room
                       & (issued <= {1'b0, last_idx})
                       & ~cfg_abort & ~rst;

   assign m_axis.tlast = m_axis.tvalid & is_last;
   assign busy         = (state != IDLE);
   assign done         = fire & is_last & ~cfg_abort & ~rst;

`ifdef ADC_CAPTURE_CTRL_TUSER_EN
   assign m_axis.tuser = m_axis.tvalid
                       & ((is_last && last_idx != '0) ? overflow
                                                      : (out_cnt == '0));
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state and write-accept decode
   always_comb begin
      state_nxt = state;
      wr_ok     = 1'b0;
      unique case (state)
         IDLE:  if (cfg_start) state_nxt = ARMED;
         ARMED: if (trig) state_nxt = CAPTURE;
         CAPTURE: begin
            wr_ok = adc_valid & ~fifo_full;
            if (wr_ok && wr_cnt == last_idx) state_nxt = FLUSH;
         end
         FLUSH: if (fire && is_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (cfg_abort) state_nxt = IDLE;
   end

   // packet length, write/beat counters, overflow and read-latency flag
   always_ff @(posedge clk) begin
      if (rst) begin
         last_idx <= '0;
         wr_cnt   <= '0;
         out_cnt  <= '0;
         overflow <= 1'b0;
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_read;
         if (start_ok) begin
            last_idx <= (cfg_pkt_len == '0) ? '0 : cfg_pkt_len - LEN_W'(1);
            wr_cnt   <= '0;
            out_cnt  <= '0;
            overflow <= 1'b0;
         end else begin
            if (fifo_write) wr_cnt <= wr_cnt + LEN_W'(1);
            if (fire) out_cnt <= out_cnt + LEN_W'(1);
            if (state == CAPTURE && adc_valid && fifo_full) overflow <= 1'b1;
         end
      end
   end

   axis_skid2 #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .clear     (cfg_abort),
      .load      (inflight),
      .load_data (fifo_rd_data),
      .tready    (m_axis.tready),
      .tdata     (m_axis.tdata),
      .tvalid    (m_axis.tvalid),
      .occ       (occ)
   );

endmodule
